// File: rtl/cacheline_adapter_if.sv
// Arbiter-side line handshake and memory-side burst bus of the cacheline adapter.
// The adapter connects through the slave modport; the environment drives the master side.
interface cacheline_adapter_if #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH  = 32
);
  logic                   read_i;
  logic                   write_i;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic                   resp_o;
  logic                   read_o;
  logic                   write_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic                   resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, read_o, write_o, address_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, read_o, write_o, address_o, burst_o
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts one line-wide read/write request into a BEATS-long burst on the memory bus,
// assembling read beats into line_o and slicing the latched write line onto burst_o.
module cacheline_adapter #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input logic                clk,
  input logic                rst,
  cacheline_adapter_if.slave bus
);
  localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [LINE_WIDTH-1:0] wline;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      wline         <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.resp_o    <= 1'b0;
      bus.address_o <= '0;
      bus.line_o    <= '0;
    end else begin
      bus.resp_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            cnt           <= '0;
            bus.address_o <= bus.address_i & ~OFF_MASK;
          end
          if (bus.write_i) begin
            state       <= WRITE;
            wline       <= bus.line_i;
            bus.write_o <= 1'b1;
          end else if (bus.read_i) begin
            state      <= READ;
            bus.read_o <= 1'b1;
          end
        end
        READ, WRITE: begin
          if (bus.resp_i) begin
            if (state == READ)
              bus.line_o[int'(cnt)*BURST_WIDTH +: BURST_WIDTH] <= bus.burst_i;
            cnt <= cnt + 1'b1;
            // Request drops and resp_o rises together so both take effect in DONE.
            if (cnt == LAST) begin
              state       <= DONE;
              bus.read_o  <= 1'b0;
              bus.write_o <= 1'b0;
              bus.resp_o  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.burst_o = '0;
    if (state == WRITE)
      bus.burst_o = wline[int'(cnt)*BURST_WIDTH +: BURST_WIDTH];
  end
endmodule
